// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared width, count type and default rate for the clock divider
package clk_div_pkg;

    localparam int CLK_DIV_W = 33;

    typedef logic [CLK_DIV_W-1:0] div_cnt_t;

    // System default half-period terminal count (2^17)
    localparam div_cnt_t DIV_DEFAULT = 33'h0_0002_0000;

endpackage

// File: rtl/div_counter.sv
// rtl/div_counter.sv - half-period counter with shadowed terminal count
module div_counter
    import clk_div_pkg::*;
#(
    parameter int WIDTH = CLK_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] max_val,
    output logic             tc
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] max_q;

    // Full-width equality against the shadowed limit; all-ones simply wraps to zero
    assign tc = (cnt == max_q);

    // Count up to the shadowed limit, then restart and resample max_val for the next half-period
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            max_q <= max_val;
        end else if (tc) begin
            cnt   <= '0;
            max_q <= max_val;
        end else begin
            cnt   <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/var_clk_divider.sv
// rtl/var_clk_divider.sv - programmable 50% duty clock divider with toggle-aligned tick
module var_clk_divider
    import clk_div_pkg::*;
#(
    parameter int WIDTH = CLK_DIV_W
) (
    input  logic             DIV_CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] MAX_VAL,
    output logic             STAB_RATE_OUT,
    output logic             STAB_TICK
);

    logic tc;
    logic out_q;
    logic tick_q;

    div_counter #(
        .WIDTH (WIDTH)
    ) u_div_counter (
        .clk     (DIV_CLK),
        .rst     (RST),
        .max_val (MAX_VAL),
        .tc      (tc)
    );

    // Toggle the output and raise the tick on each terminal count; both come straight from flops
    always_ff @(posedge DIV_CLK) begin
        if (RST) begin
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else if (tc) begin
            out_q  <= ~out_q;
            tick_q <= 1'b1;
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign STAB_RATE_OUT = out_q;
    assign STAB_TICK     = tick_q;

endmodule

// File: tb/tb_var_clk_divider.sv
// tb/tb_var_clk_divider.sv - self-checking bench for var_clk_divider
module tb_var_clk_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [32:0] max_val = 33'd3;
    logic        rate_out;
    logic        tick;

    logic [3:0]  small_max = 4'hF;
    logic        small_out;
    logic        small_tick;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    var_clk_divider dut (
        .DIV_CLK       (clk),
        .RST           (rst),
        .MAX_VAL       (max_val),
        .STAB_RATE_OUT (rate_out),
        .STAB_TICK     (tick)
    );

    var_clk_divider #(.WIDTH(4)) dut_small (
        .DIV_CLK       (clk),
        .RST           (rst),
        .MAX_VAL       (small_max),
        .STAB_RATE_OUT (small_out),
        .STAB_TICK     (small_tick)
    );

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute edge numbers of scheduled toggles
    longint edge_n = 0;
    longint next_toggle = 0;
    bit     m_out = 0;
    bit     m_tick = 0;
    bit     m_valid = 0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_out = 0;
            m_tick = 0;
            m_valid = 1;
            next_toggle = edge_n + longint'(max_val) + 1;
        end else if (edge_n == next_toggle) begin
            m_out = ~m_out;
            m_tick = 1;
            next_toggle = edge_n + longint'(max_val) + 1;
        end else begin
            m_tick = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_out", rate_out, m_out);
            check("model_tick", tick, m_tick);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [32:0] mv, input int cycles);
        max_val = mv;
        rst = 1'b1;
        repeat (cycles) step();
        check("reset_out", rate_out, 1'b0);
        check("reset_tick", tick, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // MAX_VAL=3 literal pattern, plus 4-bit all-ones wrap on the small instance
        do_reset(33'd3, 2);
        for (int k = 1; k <= 34; k++) begin
            step();
            if (k <= 12) begin
                check("mv3_out", rate_out, (k >= 4 && k < 8) || k >= 12);
                check("mv3_tick", tick, k == 4 || k == 8 || k == 12);
            end
            check("wrap_out", small_out, k >= 16 && k < 32);
            check("wrap_tick", small_tick, k == 16 || k == 32);
        end

        // MAX_VAL=0: toggle every edge, tick held high
        do_reset(33'd0, 1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("mv0_out", rate_out, k[0]);
            check("mv0_tick", tick, 1'b1);
        end

        // MAX_VAL 9 -> 2 changed at cnt=5
        do_reset(33'd9, 1);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 5) max_val = 33'd2;
            if (k >= 6) begin
                check("chg_out", rate_out, (k >= 10 && k < 13) || k >= 16);
                check("chg_tick", tick, k == 10 || k == 13 || k == 16);
            end
        end

        // Mid-count reset at cnt=6 with out=1
        do_reset(33'd9, 1);
        repeat (16) step();
        check("pre_rst_out", rate_out, 1'b1);
        rst = 1'b1;
        step();
        check("mid_rst_out", rate_out, 1'b0);
        check("mid_rst_tick", tick, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("post_rst_out", rate_out, k == 10);
            check("post_rst_tick", tick, k == 10);
        end

        // Randomized MAX_VAL changes and occasional resets, checked by the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)
                max_val = 33'($urandom_range(0, 12));
            if ($urandom_range(0, 8) == 0)
                max_val[32] = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 199) == 0);
            if (max_val[32]) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        max_val = 33'd1;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/var_clk_divider.md
Name: var_clk_divider

Overview:
- Programmable clock divider. It produces a 50%-duty square wave, STAB_RATE_OUT, from the system clock DIV_CLK.
- The half-period is set at run time by the 33-bit input MAX_VAL, so the output rate can be changed without resynthesis.
- It sits between the board clock and slower logic that needs a selectable rate, such as display refresh or debounce stabilisation.
- It also provides a one-cycle tick strobe, aligned with each toggle, for synchronous consumers.

Parameters:
- WIDTH, 33: width of MAX_VAL, the internal counter and the shadow register.

Ports:
- DIV_CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- MAX_VAL  input  WIDTH  terminal count; the output toggles every MAX_VAL+1 DIV_CLK cycles.
- STAB_RATE_OUT  output  1  divided clock, registered and glitch-free.
- STAB_TICK  output  1  one-cycle pulse, high in the cycle immediately after each toggle of STAB_RATE_OUT.

Interface note: one clock; reset is synchronous and active-high (DIV_CLK, RST).

Behaviour:
- State: count register cnt[WIDTH-1:0], shadow register max_q[WIDTH-1:0], output register out, tick register tick.
- Reset: on a rising edge with RST=1, set cnt=0, out=0 and tick=0, and load max_q from MAX_VAL. STAB_RATE_OUT=0 and STAB_TICK=0 while RST is high. Asserting RST mid-count aborts the current half-period immediately at that edge.
- Normal rising edge (RST=0):
  - If cnt == max_q: cnt <= 0, out <= ~out, tick <= 1, max_q <= MAX_VAL.
  - Otherwise: cnt <= cnt+1, tick <= 0.
- Timing: the first toggle occurs on the (MAX_VAL+1)th rising edge after RST deasserts. Output period = 2*(MAX_VAL+1) DIV_CLK cycles at exactly 50% duty.
- MAX_VAL is sampled only at reset and at each terminal count.
  - A change mid half-period takes effect from the next half-period.
  - The count never overshoots a newly reduced value, and no runt pulse is produced.
- MAX_VAL=0: the output toggles every cycle (DIV_CLK/2), and STAB_TICK stays high continuously.
- MAX_VAL = all ones (2^33-1): the counter reaches the terminal value and wraps to 0 without overflow. Comparison is a full-width equality.
- All arithmetic is unsigned WIDTH-bit. cnt+1 never exceeds max_q, so no carry-out is needed.
- Outputs are driven directly from flops; there is no combinational path from MAX_VAL to any output.
- X or Z on MAX_VAL outside the sampling edges has no effect.

Decomposition:
- Package clk_div_pkg holds:
  - localparam CLK_DIV_W = 33;
  - the typedef logic [CLK_DIV_W-1:0] div_cnt_t;
  - the constant DIV_DEFAULT = 33'h0_0002_0000 (2^17), the system default rate.
- One sub-module is natural: div_counter, containing the cnt/max_q load-and-compare with a terminal-count output. The top level holds the toggle and tick flops.

Test Plan:
- MAX_VAL=3, RST high for 2 cycles then low -> STAB_RATE_OUT rises at edge 4, falls at edge 8, rises at edge 12; STAB_TICK pulses at edges 4, 8 and 12; period 8 cycles.
- MAX_VAL=0 -> output toggles every edge (period 2 cycles); STAB_TICK held at 1.
- MAX_VAL=2^17 (131072), 10 ns clock -> toggles every 131073 cycles, half-period 1,310,730 ns, full period 2,621,460 ns; duty exactly 50%.
- MAX_VAL=9 running, changed to 2 at cnt=5 -> the current half-period still completes at cnt=9 (10 cycles); subsequent half-periods are 3 cycles; no glitch.
- Assert RST for 1 cycle at cnt=6 with out=1 -> next cycle out=0 and cnt=0; with MAX_VAL=9 the first toggle then occurs 10 edges after RST drops.
- MAX_VAL=2^33-1 forced via a cnt preload in a formal or short sim -> at cnt=all ones the output toggles and cnt wraps to 0 with no X.
